// File: rtl/ele_requant_pack_if.sv
// Bus bundle for ele_requant_pack: job control, element stream in, packed BRAM writes out.
interface ele_requant_pack_if #(
  parameter int INT32_WIDTH = 32,
  parameter int ADDR_WIDTH  = 13,
  parameter int CNT_WIDTH   = 18,
  parameter int WORD_WIDTH  = 64
);
  logic                   start_i;
  logic [ADDR_WIDTH-1:0]  base_addr_i;
  logic [CNT_WIDTH-1:0]   num_elems_i;
  logic [INT32_WIDTH-1:0] output_multiplier_i;
  logic [4:0]             output_shift_i;
  logic [INT32_WIDTH-1:0] output_zero_point_i;
  logic [INT32_WIDTH-1:0] data_i;
  logic                   valid_i;
  logic                   wr_en_o;
  logic [ADDR_WIDTH-1:0]  wr_addr_o;
  logic [WORD_WIDTH-1:0]  wr_data_o;
  logic                   busy_o;
  logic                   done_o;
  logic [CNT_WIDTH-1:0]   elem_cnt_o;

  modport master (
    output start_i, base_addr_i, num_elems_i, output_multiplier_i, output_shift_i,
           output_zero_point_i, data_i, valid_i,
    input  wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, elem_cnt_o
  );

  modport slave (
    input  start_i, base_addr_i, num_elems_i, output_multiplier_i, output_shift_i,
           output_zero_point_i, data_i, valid_i,
    output wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, elem_cnt_o
  );
endinterface

// File: rtl/ele_requant_pack.sv
// Requantizes a stream of int32 results to int8 and packs 8 bytes per 64-bit BRAM word.
module ele_requant_pack #(
  parameter int INT32_WIDTH = 32,
  parameter int INT8_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 13,
  parameter int PACK        = 8,
  parameter int CNT_WIDTH   = 18
) (
  input logic clk,
  input logic rst,
  ele_requant_pack_if.slave bus
);
  localparam int WORD_W = PACK * INT8_WIDTH;
  localparam int LANE_W = $clog2(PACK);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;

  logic [CNT_WIDTH-1:0]   num_q;
  logic [INT32_WIDTH-1:0] mult_q;
  logic [4:0]             shift_q;
  logic [INT32_WIDTH-1:0] zp_q;
  logic [CNT_WIDTH-1:0]   elem_cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;

  logic                   v1, l1, v2, l2;
  logic signed [63:0]     prod_q;
  logic [INT8_WIDTH-1:0]  byte_q;

  logic [LANE_W-1:0]      lane_q;
  logic [WORD_W-1:0]      word_q;
  logic [WORD_W-1:0]      word_nx;
  logic                   wr_en_q;
  logic                   wr_last_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [WORD_W-1:0]      wr_data_q;

  logic start_go, accept, last_in;
  logic [5:0]             sh;
  logic signed [63:0]     rnd, rsh, q;
  logic [INT8_WIDTH-1:0]  sat;

  assign start_go = (state == IDLE) && bus.start_i;
  assign accept   = (state == RUN) && bus.valid_i && (elem_cnt < num_q);
  assign last_in  = (CNT_WIDTH'(elem_cnt + 1'b1) == num_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_i) state_nx = (bus.num_elems_i == '0) ? DONE : RUN;
      RUN:     if (accept && last_in) state_nx = FLUSH;
      FLUSH:   if (wr_en_q && wr_last_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q    <= '0;
      mult_q   <= '0;
      shift_q  <= '0;
      zp_q     <= '0;
      elem_cnt <= '0;
    end else if (start_go) begin
      num_q    <= bus.num_elems_i;
      mult_q   <= bus.output_multiplier_i;
      shift_q  <= bus.output_shift_i;
      zp_q     <= bus.output_zero_point_i;
      elem_cnt <= '0;
    end else if (accept) begin
      elem_cnt <= elem_cnt + 1'b1;
    end
  end

  // Rounding right shift by 31+shift, zero-point add, then saturate to int8.
  always_comb begin
    sh  = 6'd31 + {1'b0, shift_q};
    rnd = 64'sd1 <<< (sh - 6'd1);
    rsh = (prod_q + rnd) >>> sh;
    q   = rsh + {{(64-INT32_WIDTH){zp_q[INT32_WIDTH-1]}}, zp_q};
    sat = q[INT8_WIDTH-1:0];
    if (q > 64'sd127)       sat = 8'h7F;
    else if (q < -64'sd128) sat = 8'h80;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      l1     <= 1'b0;
      prod_q <= '0;
      v2     <= 1'b0;
      l2     <= 1'b0;
      byte_q <= '0;
    end else begin
      v1     <= accept;
      l1     <= accept && last_in;
      prod_q <= $signed(bus.data_i) * $signed(mult_q);
      v2     <= v1;
      l2     <= l1;
      byte_q <= sat;
    end
  end

  always_comb begin
    word_nx = word_q;
    word_nx[{lane_q, 3'b000} +: INT8_WIDTH] = byte_q;
  end

  // Completed word is registered straight onto the write port, so it appears one cycle after its last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_last_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_go) begin
        addr_q <= bus.base_addr_i;
        lane_q <= '0;
        word_q <= '0;
      end else if (v2) begin
        if (lane_q == LANE_W'(PACK - 1) || l2) begin
          wr_en_q   <= 1'b1;
          wr_last_q <= l2;
          wr_addr_q <= addr_q;
          wr_data_q <= word_nx;
          addr_q    <= addr_q + 1'b1;
          lane_q    <= '0;
          word_q    <= '0;
        end else begin
          word_q <= word_nx;
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  assign bus.wr_en_o    = wr_en_q;
  assign bus.wr_addr_o  = wr_addr_q;
  assign bus.wr_data_o  = wr_data_q;
  assign bus.busy_o     = (state == RUN) || (state == FLUSH);
  assign bus.done_o     = (state == DONE);
  assign bus.elem_cnt_o = elem_cnt;
endmodule
